// File: rtl/ps2_cmd_decoder.sv
// ps2_cmd_decoder: PS/2 scan-code CDC, make/break parser and paced command queue.
// Optional: define PS2_TYPEMATIC_EN for LEFT/RIGHT auto-repeat while held.
`timescale 1ns/1ps
module ps2_cmd_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       i_clk_1M,
  input  logic       i_rst_n,
  input  logic [7:0] i_ps2_byte,
  input  logic       i_ps2_toggle,
  output logic       o_left,
  output logic       o_right,
  output logic       o_select,
  output logic       o_start,
  output logic [3:0] o_held,
  output logic       o_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  logic          s1_q, s2_q, s3_q;
  logic          evt;
  state_t        state_q, state_d;
  logic [3:0]    held_q, held_d;
  logic          push_q, push_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          key_hit;
  logic [1:0]    key_idx;
  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full, pop, wr_en;
  logic          ovf_q;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    pulse_q, pulse_d;

  assign evt = s2_q ^ s3_q;

  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_ps2_toggle;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    key_hit = 1'b1;
    key_idx = 2'd0;
    unique case (i_ps2_byte)
      8'h15:   key_idx = 2'd0;
      8'h24:   key_idx = 2'd1;
      8'h5A:   key_idx = 2'd2;
      8'h76:   key_idx = 2'd3;
      default: key_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    push_d  = 1'b0;
    cmd_d   = key_idx;
    if (evt) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_ps2_byte == 8'hF0) begin
            state_d = S_BREAK;
          end else if (i_ps2_byte == 8'hE0) begin
            state_d = S_EXT;
          end else if (key_hit) begin
            if (!held_q[key_idx]) begin
              held_d[key_idx] = 1'b1;
              push_d          = 1'b1;
            end
`ifdef PS2_TYPEMATIC_EN
            // cursor keys auto-repeat; SELECT/START stay one-shot
            else if (!key_idx[1]) begin
              push_d = 1'b1;
            end
`endif
          end
        end
        S_BREAK: begin
          if (key_hit) held_d[key_idx] = 1'b0;
          state_d = S_IDLE;
        end
        S_EXT: begin
          state_d = (i_ps2_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
        end
        S_EXT_BRK: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      held_q  <= 4'b0000;
      push_q  <= 1'b0;
      cmd_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      push_q  <= push_d;
      cmd_q   <= cmd_d;
    end
  end

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = (count_q != '0) && (gap_q == '0);
  assign wr_en = push_q && !full;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    gap_d   = (gap_q != '0) ? gap_q - GW'(1) : '0;
    pulse_d = 4'b0000;
    if (pop) begin
      gap_d   = GW'(GAP_CYCLES);
      pulse_d = 4'b0001 << mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      gap_q    <= '0;
      pulse_q  <= 4'b0000;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= cmd_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_q | (push_q & full);
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_left     = pulse_q[0];
  assign o_right    = pulse_q[1];
  assign o_select   = pulse_q[2];
  assign o_start    = pulse_q[3];
  assign o_held     = held_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// tb_ps2_cmd_decoder: directed + random byte streams against a
// queue-based reference of the command decoder.
`timescale 1ns/1ps
module tb_ps2_cmd_decoder;

  localparam int DEPTH = 2;
  localparam int GAP   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       tog = 1'b0;
  logic       o_left, o_right, o_select, o_start;
  logic [3:0] o_held;
  logic       o_overflow;

  ps2_cmd_decoder #(
    .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(GAP)
  ) dut (
    .i_clk_1M    (clk),
    .i_rst_n     (rst_n),
    .i_ps2_byte  (ps2_byte),
    .i_ps2_toggle(tog),
    .o_left      (o_left),
    .o_right     (o_right),
    .o_select    (o_select),
    .o_start     (o_start),
    .o_held      (o_held),
    .o_overflow  (o_overflow)
  );

  always #500 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] b;
  } pb_t;
  typedef struct {
    int at;
    int cmd;
  } pp_t;

  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  pb_t      pend_b[$];
  pp_t      pend_p[$];
  int       mq[$];
  int       mgap;
  bit       m_ovf;
  bit [3:0] m_held;
  bit [3:0] m_pulse;
  int       m_pref;
  int       dut_cnt[4];
  int       pulse_at[$];
  int       first_left;

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int key_of(logic [7:0] b);
    case (b)
      8'h15:   return 0;
      8'h24:   return 1;
      8'h5A:   return 2;
      8'h76:   return 3;
      default: return -1;
    endcase
  endfunction

  // m_pref: 0 none, 1 after F0, 2 after E0, 3 after E0 F0
  task automatic parse(logic [7:0] b);
    int k;
    k = key_of(b);
    case (m_pref)
      0: begin
        if (b == 8'hF0) m_pref = 1;
        else if (b == 8'hE0) m_pref = 2;
        else if (k >= 0) begin
          if (!m_held[k]) begin
            m_held[k] = 1'b1;
            pend_p.push_back('{cyc + 1, k});
          end
`ifdef PS2_TYPEMATIC_EN
          else if (k < 2) pend_p.push_back('{cyc + 1, k});
`endif
        end
      end
      1: begin
        if (k >= 0) m_held[k] = 1'b0;
        m_pref = 0;
      end
      2: m_pref = (b == 8'hF0) ? 3 : 0;
      default: m_pref = 0;
    endcase
  endtask

  task automatic model_edge();
    bit was_full;
    was_full = (mq.size() == DEPTH);
    m_pulse = 4'b0000;
    if (mq.size() > 0 && mgap == 0) begin
      m_pulse[mq[0]] = 1'b1;
      void'(mq.pop_front());
      mgap = GAP;
    end else if (mgap > 0) begin
      mgap--;
    end
    if (pend_p.size() > 0 && pend_p[0].at == cyc) begin
      if (was_full) m_ovf = 1'b1;
      else mq.push_back(pend_p[0].cmd);
      void'(pend_p.pop_front());
    end
    if (pend_b.size() > 0 && pend_b[0].at == cyc) begin
      parse(pend_b[0].b);
      void'(pend_b.pop_front());
    end
  endtask

  task automatic model_reset();
    pend_b.delete();
    pend_p.delete();
    mq.delete();
    mgap = 0;
    m_ovf = 1'b0;
    m_held = 4'b0000;
    m_pulse = 4'b0000;
    m_pref = 0;
  endtask

  task automatic check_outs();
    chk("pulse", {o_start, o_select, o_right, o_left}, m_pulse);
    chk("held", o_held, m_held);
    chk("ovf", {3'b000, o_overflow}, {3'b000, m_ovf});
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outs();
    if (o_left)   dut_cnt[0]++;
    if (o_right)  dut_cnt[1]++;
    if (o_select) dut_cnt[2]++;
    if (o_start)  dut_cnt[3]++;
    if (o_left | o_right | o_select | o_start) pulse_at.push_back(cyc);
    if (o_left && first_left < 0) first_left = cyc;
  endtask

  task automatic send(logic [7:0] b, int gap);
    ps2_byte = b;
    tog = ~tog;
    pend_b.push_back('{cyc + 3, b});
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tog = 1'b0;
    ps2_byte = 8'h00;
    #1;
    model_reset();
    check_outs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int base, t0, exp_l;
  logic [7:0] rb;

  initial begin
    for (int i = 0; i < 4; i++) dut_cnt[i] = 0;
    model_reset();
    first_left = -1;
    do_reset();

    // 1: single LEFT press, latency and held mask
    t0 = cyc;
    send(8'h15, 14);
    chk_int("t1_latency", first_left - t0, 5);
    chk_int("t1_left_pulses", dut_cnt[0], 1);
    chk("t1_held", o_held, 4'b0001);

    // 2: RIGHT make then break
    base = dut_cnt[1];
    send(8'h24, 4);
    chk("t2_held_make", o_held, 4'b0011);
    send(8'hF0, 3);
    send(8'h24, 14);
    chk_int("t2_right_pulses", dut_cnt[1] - base, 1);
    chk("t2_held_break", o_held, 4'b0001);

    // 3: repeated makes
    base = dut_cnt[2];
    repeat (3) send(8'h5A, 12);
    chk_int("t3_select_pulses", dut_cnt[2] - base, 1);
    send(8'hF0, 3);
    send(8'h15, 4);
    base = dut_cnt[0];
    repeat (3) send(8'h15, 12);
`ifdef PS2_TYPEMATIC_EN
    exp_l = 3;
`else
    exp_l = 1;
`endif
    chk_int("t3_left_pulses", dut_cnt[0] - base, exp_l);

    // 4: queued commands, pacing
    send(8'hF0, 3);
    send(8'h15, 3);
    send(8'hF0, 3);
    send(8'h5A, 14);
    pulse_at.delete();
    send(8'h15, 3);
    send(8'h24, 3);
    send(8'h76, 30);
    chk_int("t4_pulse_count", pulse_at.size(), 3);
    if (pulse_at.size() == 3) begin
      chk_int("t4_gap_a", pulse_at[1] - pulse_at[0], GAP + 1);
      chk_int("t4_gap_b", pulse_at[2] - pulse_at[1], GAP + 1);
    end

    // 5: extended codes never map
    send(8'hF0, 3);
    send(8'h15, 3);
    send(8'hF0, 3);
    send(8'h24, 3);
    send(8'hF0, 3);
    send(8'h76, 14);
    chk("t5_held_pre", o_held, 4'b0000);
    pulse_at.delete();
    send(8'hE0, 3);
    send(8'h15, 3);
    send(8'hE0, 3);
    send(8'hF0, 3);
    send(8'h24, 14);
    chk_int("t5_pulses", pulse_at.size(), 0);
    chk("t5_held", o_held, 4'b0000);

    // 6: burst overflows the queue, then reset mid-stream
    send(8'h15, 3);
    send(8'h24, 3);
    send(8'h5A, 3);
    send(8'h76, 3);
    send(8'hF0, 3);
    send(8'h15, 3);
    send(8'hF0, 3);
    send(8'h24, 3);
    send(8'h15, 3);
    send(8'hE0, 2);
    chk("t6_overflow", {3'b000, o_overflow}, 4'b0001);
    do_reset();
    chk("t6_rst_held", o_held, 4'b0000);
    first_left = -1;
    base = dut_cnt[0];
    t0 = cyc;
    send(8'h15, 14);
    chk_int("t6_post_latency", first_left - t0, 5);
    chk_int("t6_post_left", dut_cnt[0] - base, 1);
    chk("t6_post_held", o_held, 4'b0001);

    // random byte stream
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0:       rb = 8'h15;
        1:       rb = 8'h24;
        2:       rb = 8'h5A;
        3:       rb = 8'h76;
        4, 5:    rb = 8'hF0;
        6:       rb = 8'hE0;
        default: rb = 8'($urandom);
      endcase
      send(rb, $urandom_range(3, 12));
    end
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
